// File: rtl/lms_sequencer.sv
// Adaptive FIR channel sequencer: accepts x/d pairs, drives an external delay line,
// computes y and e with one shared multiplier, then runs an LMS coefficient update.
//
// state  | meaning
// IDLE   | ready for a new x/d pair
// SHIFT  | one-cycle shift pulse to the delay line
// FILTER | DEPTH multiply-accumulate steps producing y and e
// OUT    | holding y/e until the consumer accepts
// UPDATE | DEPTH coefficient update steps
module lms_sequencer #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int MU_SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH-1:0]         s_x,
    input  logic [WIDTH-1:0]         s_d,
    input  logic                     adapt_en,
    output logic                     tdl_shift,
    output logic [WIDTH-1:0]         tdl_din,
    input  logic [DEPTH*WIDTH-1:0]   taps,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH-1:0]         m_y,
    output logic [WIDTH-1:0]         m_e,
    output logic                     busy
);

    localparam int KW = $clog2(DEPTH);
    localparam int AW = 2*WIDTH + KW;
    localparam logic [KW-1:0] KLAST = KW'(DEPTH-1);
    localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SHIFT, FILTER, OUT, UPDATE} state_t;

    state_t                    state;
    logic [KW-1:0]             k;
    logic signed [AW-1:0]      acc;
    logic signed [WIDTH-1:0]   d_q;
    logic signed [WIDTH-1:0]   coef [DEPTH];

    logic signed [WIDTH-1:0]   tap_k;
    logic signed [WIDTH-1:0]   coef_k;
    logic signed [WIDTH-1:0]   mul_a;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW-1:0]      acc_next;
    logic signed [AW-1:0]      acc_shift;
    logic signed [WIDTH-1:0]   y_new;
    logic signed [WIDTH:0]     e_sum;
    logic signed [WIDTH-1:0]   e_new;
    logic signed [WIDTH:0]     delta;
    logic signed [WIDTH:0]     upd_sum;
    logic signed [WIDTH-1:0]   upd_new;

    function automatic logic signed [WIDTH-1:0] sat_acc(input logic signed [AW-1:0] v);
        if (v[AW-1:WIDTH-1] == '0 || v[AW-1:WIDTH-1] == '1)
            return v[WIDTH-1:0];
        return v[AW-1] ? SMIN : SMAX;
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_one(input logic signed [WIDTH:0] v);
        if (v[WIDTH] == v[WIDTH-1])
            return v[WIDTH-1:0];
        return v[WIDTH] ? SMIN : SMAX;
    endfunction

    always_comb begin
        tap_k  = '0;
        coef_k = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (k == KW'(i)) begin
                tap_k  = taps[i*WIDTH +: WIDTH];
                coef_k = coef[i];
            end
        end
    end

    // The single multiplier: coef*tap while filtering, e*tap while updating.
    assign mul_a = (state == UPDATE) ? $signed(m_e) : coef_k;
    assign prod  = mul_a * tap_k;

    assign acc_next  = acc + {{KW{prod[2*WIDTH-1]}}, prod};
    assign acc_shift = acc_next >>> (WIDTH-1);
    assign y_new     = sat_acc(acc_shift);
    assign e_sum     = {d_q[WIDTH-1], d_q} - {y_new[WIDTH-1], y_new};
    assign e_new     = sat_one(e_sum);

    // |e*tap| <= 2^(2*WIDTH-2), so the shifted step always fits in WIDTH+1 bits.
    assign delta   = (WIDTH+1)'(prod >>> (WIDTH-1+MU_SHIFT));
    assign upd_sum = {coef_k[WIDTH-1], coef_k} + delta;
    assign upd_new = sat_one(upd_sum);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            k         <= '0;
            acc       <= '0;
            d_q       <= '0;
            s_ready   <= 1'b1;
            tdl_shift <= 1'b0;
            tdl_din   <= '0;
            m_valid   <= 1'b0;
            m_y       <= '0;
            m_e       <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                coef[i] <= '0;
        end else begin
            tdl_shift <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        d_q       <= s_d;
                        tdl_din   <= s_x;
                        acc       <= '0;
                        k         <= '0;
                        tdl_shift <= 1'b1;
                        s_ready   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    k     <= '0;
                    state <= FILTER;
                end
                FILTER: begin
                    acc <= acc_next;
                    if (k == KLAST) begin
                        m_y     <= y_new;
                        m_e     <= e_new;
                        m_valid <= 1'b1;
                        k       <= '0;
                        state   <= OUT;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        k       <= '0;
                        if (adapt_en) begin
                            state <= UPDATE;
                        end else begin
                            s_ready <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                UPDATE: begin
                    coef[k] <= upd_new;
                    if (k == KLAST) begin
                        k       <= '0;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lms_sequencer.sv
// Self-checking bench for lms_sequencer: behavioural delay line plus an integer
// reference model of the filter output, error and LMS update.
module tb_lms_sequencer;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int MU = 0;

    logic clk = 1'b0;
    logic rstn;
    logic s_valid, s_ready;
    logic [W-1:0] s_x, s_d;
    logic adapt_en, tdl_shift;
    logic [W-1:0] tdl_din;
    logic [D*W-1:0] taps;
    logic m_valid, m_ready;
    logic [W-1:0] m_y, m_e;
    logic busy;
    logic tdl_clr;
    logic [W-1:0] tdl [D];

    int tests = 0;
    int fails = 0;
    int mcoef [D];
    int mtap  [D];

    always #5 clk = ~clk;

    lms_sequencer #(.WIDTH(W), .DEPTH(D), .MU_SHIFT(MU)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_d(s_d),
        .adapt_en(adapt_en), .tdl_shift(tdl_shift), .tdl_din(tdl_din), .taps(taps),
        .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_e(m_e), .busy(busy)
    );

    // External delay line
    always @(posedge clk) begin
        if (tdl_clr) begin
            for (int i = 0; i < D; i++) tdl[i] <= '0;
        end else if (tdl_shift) begin
            for (int i = D-1; i > 0; i--) tdl[i] <= tdl[i-1];
            tdl[0] <= tdl_din;
        end
    end

    always_comb begin
        taps = '0;
        for (int i = 0; i < D; i++) taps[i*W +: W] = tdl[i];
    end

    function automatic int sat(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic model_push(input int x);
        for (int i = D-1; i > 0; i--) mtap[i] = mtap[i-1];
        mtap[0] = x;
    endtask

    task automatic model_out(input int d, output int y, output int e);
        longint acc;
        acc = 0;
        for (int i = 0; i < D; i++) acc += longint'(mcoef[i]) * longint'(mtap[i]);
        y = sat(acc >>> (W-1));
        e = sat(longint'(d) - longint'(y));
    endtask

    task automatic model_adapt(input int e);
        for (int i = 0; i < D; i++)
            mcoef[i] = sat(longint'(mcoef[i]) + ((longint'(e) * longint'(mtap[i])) >>> (W-1+MU)));
    endtask

    task automatic model_clear_coef();
        for (int i = 0; i < D; i++) mcoef[i] = 0;
    endtask

    function automatic int rnd_sample();
        logic signed [W-1:0] r;
        r = W'($urandom);
        return int'(r);
    endfunction

    // One full transaction; checks shift pulse, latency, data, hold stability and period.
    task automatic run_pair(input int x, input int d, input bit adapt, input int hold,
                            output int got_y, output int got_e);
        int cyc, extra, bad, ey, ee;
        logic [W-1:0] y0, e0;
        got_y = 0;
        got_e = 0;
        cyc = 0;
        while (!s_ready && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        tests++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_wait: s_ready=%b after %0d cycles, want 1", s_ready, cyc);
            return;
        end
        s_valid = 1'b1; s_x = W'(x); s_d = W'(d); adapt_en = ~adapt;
        @(posedge clk); #1;
        s_valid = 1'b0; s_x = W'($urandom); s_d = W'($urandom);
        model_push(x);
        model_out(d, ey, ee);
        tests++;
        if (tdl_shift !== 1'b1 || tdl_din !== W'(x) || s_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL shift_pulse: tdl_shift=%b tdl_din=%0d s_ready=%b busy=%b, want 1 %0d 0 1",
                     tdl_shift, $signed(tdl_din), s_ready, busy, x);
        end
        cyc = 1; extra = 0;
        while (!m_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            if (tdl_shift || s_ready) extra++;
        end
        tests++;
        if (cyc != D+2 || extra != 0) begin
            fails++;
            $display("FAIL latency: m_valid at cycle %0d with %0d stray shift/ready, want %0d and 0",
                     cyc, extra, D+2);
        end
        if (m_valid !== 1'b1) return;
        got_y = int'($signed(m_y));
        got_e = int'($signed(m_e));
        tests++;
        if (got_y != ey || got_e != ee) begin
            fails++;
            $display("FAIL data: got y=%0d e=%0d, want y=%0d e=%0d (x=%0d d=%0d)", got_y, got_e, ey, ee, x, d);
        end
        y0 = m_y; e0 = m_e;
        for (int h = 0; h < hold; h++) begin
            m_ready = 1'b0; adapt_en = $urandom_range(0, 1);
            @(posedge clk); #1; cyc++;
            tests++;
            if (m_valid !== 1'b1 || m_y !== y0 || m_e !== e0 || s_ready !== 1'b0 || tdl_shift !== 1'b0) begin
                fails++;
                $display("FAIL hold: m_valid=%b y=%0d e=%0d s_ready=%b shift=%b, want 1 %0d %0d 0 0",
                         m_valid, $signed(m_y), $signed(m_e), s_ready, tdl_shift, $signed(y0), $signed(e0));
            end
        end
        m_ready = 1'b1; adapt_en = adapt;
        @(posedge clk); #1; cyc++;
        m_ready = 1'b0; adapt_en = ~adapt;
        if (adapt) model_adapt(ee);
        bad = 0;
        while (!s_ready && cyc < 100) begin
            if (m_valid || tdl_shift) bad++;
            @(posedge clk); #1; cyc++;
        end
        tests++;
        if (cyc != (adapt ? 2*D+3 : D+3) + hold || bad != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL period: %0d cycles, %0d stray valid/shift, busy=%b, want %0d 0 0",
                     cyc, bad, busy, (adapt ? 2*D+3 : D+3) + hold);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        tests++;
        if (s_ready !== 1'b1 || tdl_shift !== 1'b0 || tdl_din !== '0 || m_valid !== 1'b0 ||
            m_y !== '0 || m_e !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s: ready=%b shift=%b din=%h valid=%b y=%h e=%h busy=%b, want 1 0 0 0 0 0 0",
                     name, s_ready, tdl_shift, tdl_din, m_valid, m_y, m_e, busy);
        end
    endtask

    task automatic test_reset();
        int stray;
        rstn = 1'b0; tdl_clr = 1'b1;
        s_valid = 1'b0; s_x = '0; s_d = '0; adapt_en = 1'b0; m_ready = 1'b0;
        model_clear_coef();
        for (int i = 0; i < D; i++) mtap[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        rstn = 1'b1; tdl_clr = 1'b0;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (tdl_shift !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1) stray++;
        end
        tests++;
        if (stray != 0) begin
            fails++;
            $display("FAIL idle: %0d idle cycles with activity, want 0", stray);
        end
    endtask

    task automatic test_directed();
        int y, e;
        run_pair(16384, 16384, 1'b1, 0, y, e);
        tests++;
        if (y != 0 || e != 16384) begin
            fails++;
            $display("FAIL first_sample: got y=%0d e=%0d, want 0 16384", y, e);
        end
        run_pair(16384, 0, 1'b1, 0, y, e);
        tests++;
        if (y != 4096 || e != -4096) begin
            fails++;
            $display("FAIL second_sample: got y=%0d e=%0d, want 4096 -4096", y, e);
        end
    endtask

    task automatic test_backpressure();
        int y, e;
        run_pair(rnd_sample() / 4, rnd_sample() / 4, 1'b1, 5, y, e);
        run_pair(rnd_sample() / 4, rnd_sample() / 4, 1'b1, 0, y, e);
    endtask

    task automatic test_random();
        int y, e;
        for (int n = 0; n < 24; n++)
            run_pair(rnd_sample(), rnd_sample(), 1'($urandom_range(0, 1)), $urandom_range(0, 3), y, e);
    endtask

    task automatic test_no_adapt();
        int y1, e1, y2, e2, x;
        x = rnd_sample();
        for (int i = 0; i < D; i++) run_pair(x, 0, 1'b0, 0, y1, e1);
        run_pair(x, 0, 1'b0, 0, y2, e2);
        tests++;
        if (y1 != y2) begin
            fails++;
            $display("FAIL no_adapt_stable: got y=%0d then %0d, want equal", y1, y2);
        end
    endtask

    task automatic test_reset_mid_filter();
        int x, y, e;
        x = rnd_sample();
        s_valid = 1'b1; s_x = W'(x); s_d = W'($urandom);
        @(posedge clk); #1;
        s_valid = 1'b0;
        model_push(x);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check_reset_outputs("reset_mid_filter");
        model_clear_coef();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        run_pair(rnd_sample(), rnd_sample(), 1'b0, 0, y, e);
        tests++;
        if (y != 0) begin
            fails++;
            $display("FAIL after_reset_y: got y=%0d, want 0", y);
        end
    endtask

    task automatic test_saturation();
        int y, e;
        for (int i = 0; i < D; i++) run_pair(-32768, 0, 1'b0, 0, y, e);
        run_pair(-32768, -32768, 1'b1, 0, y, e);
        for (int i = 0; i < D; i++) run_pair(32767, -32768, 1'b0, 0, y, e);
        tests++;
        if (y != 32767 || e != -32768) begin
            fails++;
            $display("FAIL saturation: got y=%0d e=%0d, want 32767 -32768", y, e);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_no_adapt();
        test_reset_mid_filter();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lms_sequencer.md
# lms_sequencer

Control and arithmetic sequencer for one adaptive FIR channel built around an external tapped delay line. It accepts one sample/desired pair per handshake and pulses the delay line's shift. It then time-multiplexes a single multiplier over the DEPTH taps to compute the filter output y and the error e, and runs an LMS coefficient-update pass. It sits between the sample source and the error/output consumer and owns the coefficient storage.

## Interface
- WIDTH, 16: sample, desired, tap, coefficient, y and e width (signed, Q1.(WIDTH-1)).
- DEPTH, 8: number of taps/coefficients, ≥2.
- MU_SHIFT, 4: step size as a right shift, μ = 2^-MU_SHIFT.
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- s_valid  in  1  input pair valid.
- s_ready  out  1  block can accept a pair.
- s_x  in  WIDTH  new input sample.
- s_d  in  WIDTH  desired sample.
- adapt_en  in  1  enables the update pass; sampled on OUT exit.
- tdl_shift  out  1  one-cycle shift enable to the delay line.
- tdl_din  out  WIDTH  sample to the delay line; valid while tdl_shift=1.
- taps  in  DEPTH*WIDTH  delay line contents; tap k = taps[k*WIDTH +: WIDTH], tap 0 newest.
- m_valid  out  1  y/e valid.
- m_ready  in  1  consumer accepts y/e.
- m_y  out  WIDTH  filter output.
- m_e  out  WIDTH  error d − y.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states are IDLE, SHIFT, FILTER, OUT, UPDATE.
- IDLE: s_ready=1. On s_valid&s_ready, latch s_x and s_d, clear the accumulator, and go to SHIFT.
- SHIFT (1 cycle): tdl_shift=1, tdl_din=latched x. The delay line updates at the end of this cycle. Go to FILTER with k=0.
- FILTER (DEPTH cycles, k=0..DEPTH-1): acc += coef[k]·tap[k]. The full product is 2·WIDTH bits. acc is 2·WIDTH+clog2(DEPTH) bits, signed, with no overflow possible. On the last k, register m_y and m_e, then go to OUT.
- m_y = sat_WIDTH(acc >>> (WIDTH-1)), using arithmetic shift (floor).
- m_e = sat_WIDTH(d − m_y), computed in WIDTH+1 bits.
- OUT: m_valid=1, holding m_y and m_e stable until m_ready. On m_valid&m_ready:
  - adapt_en=1: go to UPDATE with k=0.
  - adapt_en=0: go to IDLE.
- UPDATE (DEPTH cycles): coef[k] = sat_WIDTH(coef[k] + ((m_e·tap[k]) >>> (WIDTH-1+MU_SHIFT))). The sum is computed in WIDTH+1 bits. It uses the taps of the current sample, because the delay line does not shift until the next SHIFT.
- After UPDATE, go to IDLE.
- Saturation clamps to [−2^(WIDTH-1), 2^(WIDTH-1)−1].
- Only one multiplier is shared between FILTER and UPDATE.
- s_ready is 0 in every state except IDLE. The delay line shifts only in SHIFT.
- Reset mid-operation: the FSM returns to IDLE, all coefficients go to 0, the accumulator and the k counter clear, and any in-flight sample is discarded. Delay line reset is external.

## Timing
- Reset values: s_ready=1, tdl_shift=0, tdl_din=0, m_valid=0, m_y=0, m_e=0, busy=0. All coef=0.
- Handshake accepted at edge 0:
  - Cycle 1: tdl_shift=1.
  - Cycles 2..DEPTH+1: FILTER.
  - Cycle DEPTH+2: m_valid first high.
- Minimum sample period with m_ready held at 1:
  - 2·DEPTH+3 cycles with adapt.
  - DEPTH+3 cycles without adapt.
- s_ready returns high the cycle after the last UPDATE cycle, or after OUT when adapt_en=0.
- m_valid must not drop before m_ready, and m_y/m_e must not change while m_valid=1.
- adapt_en is sampled only in the OUT handshake cycle. Changes at any other time have no effect on the current sample.
- tdl_shift is exactly one pulse per accepted pair. It never appears during FILTER, OUT or UPDATE.

## Test plan
- Reset, then idle with no s_valid: s_ready=1, tdl_shift never pulses, m_valid=0.
- WIDTH=16, DEPTH=8, MU_SHIFT=0, adapt_en=1. Send x=16384, d=16384 with zero coefficients: one tdl_shift with tdl_din=16384, m_valid at cycle 10, m_y=0, m_e=16384. After UPDATE, coef0=8192 and all other coefficients stay 0.
- Continue with x=16384, d=0, so taps 0 and 1 = 16384: m_y=4096, m_e=−4096.
- Hold m_ready=0 for 5 cycles in OUT: m_valid, m_y and m_e stay stable, s_ready=0, no tdl_shift. Accept proceeds normally afterwards.
- Drive coefficients to full scale with repeated large e: coefficients saturate to 32767 and never wrap. With taps at 32767, m_y saturates to 32767, and d=−32768 gives m_e=−32768.
- adapt_en=0: period is 11 cycles and coefficients are unchanged. Assert rstn=0 during FILTER: all outputs take reset values, coefficients return to 0, and the next sample gives m_y=0.
